// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the external-memory arbiter: owner codes, wishbone CTI
// values and the arbiter state enum.
package mem_arbiter_pkg;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_CPU  = 2'd1;
   localparam logic [1:0] OWN_VID  = 2'd2;
   localparam logic [1:0] OWN_SND  = 2'd3;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CPU  = 2'd1,
      ST_VID  = 2'd2,
      ST_SND  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/arb_burst_ctr.sv
// Beat counter and low word-address incrementer for one arbiter transfer.
// The low address bits wrap inside the aligned block.
module arb_burst_ctr #(
   parameter int BURST_LEN = 4
) (
   input  logic                         clkcpu,
   input  logic                         rst_n,
   input  logic                         load,
   input  logic [$clog2(BURST_LEN)-1:0] load_lo,
   input  logic                         adv,
   output logic                         last_beat,
   output logic [$clog2(BURST_LEN)-1:0] adr_lo
);

   localparam int LW = $clog2(BURST_LEN);

   logic [LW-1:0] r_beat;
   logic [LW-1:0] r_adr_lo;

   always_ff @(posedge clkcpu or negedge rst_n) begin
      if (!rst_n) begin
         r_beat   <= '0;
         r_adr_lo <= '0;
      end else if (load) begin
         r_beat   <= '0;
         r_adr_lo <= load_lo;
      end else if (adv) begin
         r_beat   <= r_beat + 1'b1;
         r_adr_lo <= r_adr_lo + 1'b1;
      end
   end

   assign last_beat = (r_beat == LW'(BURST_LEN - 1));
   assign adr_lo    = r_adr_lo;

endmodule

// File: rtl/mem_arbiter.sv
// Shares the wishbone external-memory port between CPU single accesses and
// aligned incrementing read bursts for the video and sound DMA engines.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | bus released; arbitrate, grant takes effect next edge
//   ST_CPU  | single CPU read/write, aborts if cpu_cyc_i drops
//   ST_VID  | video read burst of BURST_LEN beats
//   ST_SND  | sound read burst of BURST_LEN beats
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int BURST_LEN      = 4,
   parameter int CPU_STARVE_MAX = 2
) (
   input  logic        clkcpu,
   input  logic        rst_n,
   input  logic        cpu_cyc_i,
   input  logic        cpu_stb_i,
   input  logic        cpu_we_i,
   input  logic [3:0]  cpu_sel_i,
   input  logic [21:0] cpu_adr_i,
   input  logic [31:0] cpu_dat_i,
   output logic        cpu_ack_o,
   input  logic        vid_req_i,
   input  logic [21:0] vid_adr_i,
   output logic        vid_ack_o,
   input  logic        snd_req_i,
   input  logic [21:0] snd_adr_i,
   output logic        snd_ack_o,
   output logic        mem_cyc_o,
   output logic        mem_stb_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_sel_o,
   output logic [2:0]  mem_cti_o,
   output logic [21:0] mem_adr_o,
   output logic [31:0] mem_dat_o,
   input  logic        mem_ack_i,
   output logic [1:0]  owner_o
);

   localparam int LW = $clog2(BURST_LEN);
   localparam int SW = $clog2(CPU_STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(CPU_STARVE_MAX);
   localparam logic [2:0]    CTI_FIRST  = (BURST_LEN == 2) ? CTI_EOB : CTI_INCR;

   arb_state_t     r_state;
   logic [SW-1:0]  r_starve;
   logic           r_cyc;
   logic           r_we;
   logic [3:0]     r_sel;
   logic [2:0]     r_cti;
   logic [21-LW:0] r_adr_hi;
   logic [31:0]    r_dat;
   logic [1:0]     r_owner;

   logic           w_cpu_req;
   logic [1:0]     w_grant;
   logic           w_load;
   logic [LW-1:0]  w_load_lo;
   logic           w_burst_ack;
   logic           w_last_beat;
   logic [LW-1:0]  w_adr_lo;
   logic           w_unused_lo;

   assign w_cpu_req = cpu_cyc_i & cpu_stb_i;

   always_comb begin
      w_grant = OWN_NONE;
      if (r_starve == STARVE_MAX && w_cpu_req)
         w_grant = OWN_CPU;
      else if (vid_req_i)
         w_grant = OWN_VID;
      else if (snd_req_i)
         w_grant = OWN_SND;
      else if (w_cpu_req)
         w_grant = OWN_CPU;
   end

   // DMA bursts always start at beat 0 of the aligned block.
   assign w_load      = (r_state == ST_IDLE) && (w_grant != OWN_NONE);
   assign w_load_lo   = (w_grant == OWN_CPU) ? cpu_adr_i[LW-1:0] : '0;
   assign w_burst_ack = mem_ack_i && (r_state == ST_VID || r_state == ST_SND);
   assign w_unused_lo = ^{vid_adr_i[LW-1:0], snd_adr_i[LW-1:0]};

   arb_burst_ctr #(.BURST_LEN(BURST_LEN)) u_burst_ctr (
      .clkcpu    (clkcpu),
      .rst_n     (rst_n),
      .load      (w_load),
      .load_lo   (w_load_lo),
      .adv       (w_burst_ack),
      .last_beat (w_last_beat),
      .adr_lo    (w_adr_lo)
   );

   always_ff @(posedge clkcpu or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_starve <= '0;
         r_cyc    <= 1'b0;
         r_we     <= 1'b0;
         r_sel    <= 4'h0;
         r_cti    <= CTI_CLASSIC;
         r_adr_hi <= '0;
         r_dat    <= 32'h0;
         r_owner  <= OWN_NONE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               case (w_grant)
                  OWN_CPU: begin
                     r_state  <= ST_CPU;
                     r_cyc    <= 1'b1;
                     r_we     <= cpu_we_i;
                     r_sel    <= cpu_sel_i;
                     r_cti    <= CTI_CLASSIC;
                     r_adr_hi <= cpu_adr_i[21:LW];
                     r_dat    <= cpu_dat_i;
                     r_owner  <= OWN_CPU;
                     r_starve <= '0;
                  end
                  OWN_VID, OWN_SND: begin
                     r_state  <= (w_grant == OWN_VID) ? ST_VID : ST_SND;
                     r_cyc    <= 1'b1;
                     r_we     <= 1'b0;
                     r_sel    <= 4'hF;
                     r_cti    <= CTI_FIRST;
                     r_adr_hi <= (w_grant == OWN_VID) ? vid_adr_i[21:LW] : snd_adr_i[21:LW];
                     r_owner  <= w_grant;
                     if (!w_cpu_req)
                        r_starve <= '0;
                     else if (r_starve != STARVE_MAX)
                        r_starve <= r_starve + 1'b1;
                  end
                  default: r_starve <= '0;
               endcase
            end
            ST_CPU: begin
               if (!cpu_cyc_i || mem_ack_i) begin
                  r_state <= ST_IDLE;
                  r_cyc   <= 1'b0;
                  r_we    <= 1'b0;
                  r_owner <= OWN_NONE;
               end
            end
            default: begin
               if (mem_ack_i) begin
                  if (w_last_beat) begin
                     r_state <= ST_IDLE;
                     r_cyc   <= 1'b0;
                     r_owner <= OWN_NONE;
                  end else if (w_adr_lo == LW'(BURST_LEN - 2)) begin
                     r_cti <= CTI_EOB;
                  end
               end
            end
         endcase
      end
   end

   assign mem_cyc_o = r_cyc;
   assign mem_stb_o = r_cyc;
   assign mem_we_o  = r_we;
   assign mem_sel_o = r_sel;
   assign mem_cti_o = r_cti;
   assign mem_adr_o = {r_adr_hi, w_adr_lo};
   assign mem_dat_o = r_dat;
   assign owner_o   = r_owner;

   assign cpu_ack_o = mem_ack_i && (r_state == ST_CPU);
   assign vid_ack_o = mem_ack_i && (r_state == ST_VID);
   assign snd_ack_o = mem_ack_i && (r_state == ST_SND);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle table of {C,V,S,ack} inputs with
// expected bus state, then CPU-write and reset-mid-burst sequences.
module tb_mem_arbiter;

   logic        clkcpu = 1'b0;
   logic        rst_n;
   logic        cpu_cyc_i, cpu_stb_i, cpu_we_i;
   logic [3:0]  cpu_sel_i;
   logic [21:0] cpu_adr_i;
   logic [31:0] cpu_dat_i;
   logic        cpu_ack_o;
   logic        vid_req_i;
   logic [21:0] vid_adr_i;
   logic        vid_ack_o;
   logic        snd_req_i;
   logic [21:0] snd_adr_i;
   logic        snd_ack_o;
   logic        mem_cyc_o, mem_stb_o, mem_we_o;
   logic [3:0]  mem_sel_o;
   logic [2:0]  mem_cti_o;
   logic [21:0] mem_adr_o;
   logic [31:0] mem_dat_o;
   logic        mem_ack_i;
   logic [1:0]  owner_o;

   mem_arbiter #(.BURST_LEN(4), .CPU_STARVE_MAX(2)) dut (
      .clkcpu    (clkcpu),
      .rst_n     (rst_n),
      .cpu_cyc_i (cpu_cyc_i),
      .cpu_stb_i (cpu_stb_i),
      .cpu_we_i  (cpu_we_i),
      .cpu_sel_i (cpu_sel_i),
      .cpu_adr_i (cpu_adr_i),
      .cpu_dat_i (cpu_dat_i),
      .cpu_ack_o (cpu_ack_o),
      .vid_req_i (vid_req_i),
      .vid_adr_i (vid_adr_i),
      .vid_ack_o (vid_ack_o),
      .snd_req_i (snd_req_i),
      .snd_adr_i (snd_adr_i),
      .snd_ack_o (snd_ack_o),
      .mem_cyc_o (mem_cyc_o),
      .mem_stb_o (mem_stb_o),
      .mem_we_o  (mem_we_o),
      .mem_sel_o (mem_sel_o),
      .mem_cti_o (mem_cti_o),
      .mem_adr_o (mem_adr_o),
      .mem_dat_o (mem_dat_o),
      .mem_ack_i (mem_ack_i),
      .owner_o   (owner_o)
   );

   always #5 clkcpu = ~clkcpu;

   typedef struct {
      logic [3:0]  in;     // {cpu_req, vid_req, snd_req, mem_ack}
      logic        e_cyc;
      logic [1:0]  e_own;
      logic [2:0]  e_cti;
      logic [21:0] e_adr;
      logic [2:0]  e_ack;  // {cpu, vid, snd}
   } vec_t;

   vec_t vq[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] in, input logic c, input logic [1:0] o,
                      input logic [2:0] t, input logic [21:0] a, input logic [2:0] k);
      vec_t v;
      v.in = in; v.e_cyc = c; v.e_own = o; v.e_cti = t; v.e_adr = a; v.e_ack = k;
      vq.push_back(v);
   endtask

   task automatic add_idle(input logic [3:0] in);
      add(in, 1'b0, 2'd0, 3'b000, 22'h0, 3'b000);
   endtask

   task automatic add_burst(input logic [3:0] in, input logic [1:0] o,
                            input logic [21:0] base, input logic [2:0] k);
      for (int b = 0; b < 4; b++)
         add(in, 1'b1, o, (b == 3) ? 3'b111 : 3'b010, base + 22'(b), k);
   endtask

   task automatic tick;
      @(posedge clkcpu);
      #1;
   endtask

   initial begin
      rst_n = 1'b1;
      cpu_cyc_i = 0; cpu_stb_i = 0; cpu_we_i = 0; cpu_sel_i = 4'hF;
      cpu_adr_i = 22'h12345; cpu_dat_i = 32'h0;
      vid_req_i = 0; vid_adr_i = 22'h00103;
      snd_req_i = 0; snd_adr_i = 22'h00206;
      mem_ack_i = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("rst cyc",   32'(mem_cyc_o), 32'd0);
      chk("rst stb",   32'(mem_stb_o), 32'd0);
      chk("rst we",    32'(mem_we_o),  32'd0);
      chk("rst sel",   32'(mem_sel_o), 32'd0);
      chk("rst cti",   32'(mem_cti_o), 32'd0);
      chk("rst adr",   32'(mem_adr_o), 32'd0);
      chk("rst owner", 32'(owner_o),   32'd0);
      chk("rst acks",  32'({cpu_ack_o, vid_ack_o, snd_ack_o}), 32'd0);
      mem_ack_i = 1'b0;
      @(posedge clkcpu);
      tick();
      rst_n = 1'b1;

      // video alone, address 0x103 aligned down to 0x100
      add_idle(4'b0100);
      add_burst(4'b0001, 2'd2, 22'h100, 3'b010);
      add_idle(4'b0000);
      // video and sound together: video first, one idle, then sound
      add_idle(4'b0110);
      add(4'b0010, 1'b1, 2'd2, 3'b010, 22'h100, 3'b000);
      add_burst(4'b0011, 2'd2, 22'h100, 3'b010);
      add_idle(4'b0010);
      add_burst(4'b0001, 2'd3, 22'h204, 3'b001);
      add_idle(4'b0001);
      // CPU read with two wait states
      add_idle(4'b1000);
      add(4'b1000, 1'b1, 2'd1, 3'b000, 22'h12345, 3'b000);
      add(4'b1000, 1'b1, 2'd1, 3'b000, 22'h12345, 3'b000);
      add(4'b1001, 1'b1, 2'd1, 3'b000, 22'h12345, 3'b100);
      add_idle(4'b0000);
      // video held with CPU pending: two bursts, CPU, then video again
      add_idle(4'b1100);
      add_burst(4'b1101, 2'd2, 22'h100, 3'b010);
      add_idle(4'b1100);
      add_burst(4'b1101, 2'd2, 22'h100, 3'b010);
      add_idle(4'b1100);
      add(4'b1101, 1'b1, 2'd1, 3'b000, 22'h12345, 3'b100);
      add_idle(4'b0100);
      add_burst(4'b0001, 2'd2, 22'h100, 3'b010);
      add_idle(4'b0000);
      // CPU abort by dropping cyc; later stray ack is ignored
      add_idle(4'b1000);
      add(4'b1000, 1'b1, 2'd1, 3'b000, 22'h12345, 3'b000);
      add(4'b0000, 1'b1, 2'd1, 3'b000, 22'h12345, 3'b000);
      add_idle(4'b0001);

      for (int i = 0; i < vq.size(); i++) begin
         {cpu_cyc_i, vid_req_i, snd_req_i, mem_ack_i} = vq[i].in;
         cpu_stb_i = vq[i].in[3];
         @(negedge clkcpu);
         chk($sformatf("r%0d cyc", i),   32'(mem_cyc_o), 32'(vq[i].e_cyc));
         chk($sformatf("r%0d stb", i),   32'(mem_stb_o), 32'(vq[i].e_cyc));
         chk($sformatf("r%0d owner", i), 32'(owner_o),   32'(vq[i].e_own));
         chk($sformatf("r%0d acks", i),  32'({cpu_ack_o, vid_ack_o, snd_ack_o}), 32'(vq[i].e_ack));
         if (vq[i].e_cyc) begin
            chk($sformatf("r%0d cti", i), 32'(mem_cti_o), 32'(vq[i].e_cti));
            chk($sformatf("r%0d adr", i), 32'(mem_adr_o), 32'(vq[i].e_adr));
            chk($sformatf("r%0d we", i),  32'(mem_we_o),  32'd0);
            chk($sformatf("r%0d sel", i), 32'(mem_sel_o), 32'hF);
         end
         tick();
      end

      // CPU write: latched we/sel/data held until ack
      cpu_cyc_i = 1; cpu_stb_i = 1; cpu_we_i = 1; cpu_sel_i = 4'b0100;
      cpu_adr_i = 22'h00777; cpu_dat_i = 32'hDEADBEEF; mem_ack_i = 0;
      @(negedge clkcpu);
      chk("wr idle owner", 32'(owner_o), 32'd0);
      tick();
      cpu_dat_i = 32'h0; cpu_sel_i = 4'hF;
      for (int k = 0; k < 3; k++) begin
         if (k == 2) mem_ack_i = 1'b1;
         @(negedge clkcpu);
         chk($sformatf("wr%0d cyc", k), 32'(mem_cyc_o), 32'd1);
         chk($sformatf("wr%0d we", k),  32'(mem_we_o),  32'd1);
         chk($sformatf("wr%0d sel", k), 32'(mem_sel_o), 32'h4);
         chk($sformatf("wr%0d dat", k), mem_dat_o,      32'hDEADBEEF);
         chk($sformatf("wr%0d adr", k), 32'(mem_adr_o), 32'h777);
         chk($sformatf("wr%0d cti", k), 32'(mem_cti_o), 32'd0);
         chk($sformatf("wr%0d ack", k), 32'(cpu_ack_o), (k == 2) ? 32'd1 : 32'd0);
         tick();
      end
      cpu_cyc_i = 0; cpu_stb_i = 0; cpu_we_i = 0; mem_ack_i = 0;
      @(negedge clkcpu);
      chk("wr end cyc",   32'(mem_cyc_o), 32'd0);
      chk("wr end owner", 32'(owner_o),   32'd0);
      tick();

      // reset pulsed after beat 1 of a sound burst
      snd_req_i = 1; snd_adr_i = 22'h00206;
      tick();
      snd_req_i = 0; mem_ack_i = 1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clkcpu);
         chk($sformatf("rs%0d adr", k), 32'(mem_adr_o), 32'h204 + 32'(k));
         chk($sformatf("rs%0d ack", k), 32'(snd_ack_o), 32'd1);
         tick();
      end
      rst_n = 1'b0;
      #1;
      chk("rs async cyc",   32'(mem_cyc_o), 32'd0);
      chk("rs async owner", 32'(owner_o),   32'd0);
      chk("rs async adr",   32'(mem_adr_o), 32'd0);
      chk("rs async cti",   32'(mem_cti_o), 32'd0);
      chk("rs async sel",   32'(mem_sel_o), 32'd0);
      chk("rs async ack",   32'(snd_ack_o), 32'd0);
      tick();
      chk("rs held ack", 32'(snd_ack_o), 32'd0);
      rst_n = 1'b1; mem_ack_i = 0; snd_req_i = 1; snd_adr_i = 22'h00311;
      @(negedge clkcpu);
      chk("rs rel cyc", 32'(mem_cyc_o), 32'd0);
      tick();
      snd_req_i = 0; mem_ack_i = 1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clkcpu);
         chk($sformatf("rn%0d owner", k), 32'(owner_o),   32'd3);
         chk($sformatf("rn%0d adr", k),   32'(mem_adr_o), 32'h310 + 32'(k));
         chk($sformatf("rn%0d cti", k),   32'(mem_cti_o), (k == 3) ? 32'h7 : 32'h2);
         chk($sformatf("rn%0d ack", k),   32'(snd_ack_o), 32'd1);
         tick();
      end
      @(negedge clkcpu);
      chk("rn end cyc", 32'(mem_cyc_o), 32'd0);
      chk("rn end ack", 32'(snd_ack_o), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
